// File: rtl/audio_feat_pkg.sv
// Shared definitions for the band feature extractor.
//   FEAT_W    : width of the signed feature output and of the scaled band values
//   NUM_BANDS : number of frequency bands per frame
//   ACC_W     : width of the per-band accumulators and hold registers
//   state_e   : output engine states (IDLE -> SCALE -> MEAN -> EMIT -> IDLE)
//   sat_shift : right-shift a band sum and clamp it to the positive feature range
package audio_feat_pkg;

  localparam int FEAT_W    = 16;
  localparam int NUM_BANDS = 4;
  localparam int ACC_W     = 32;
  localparam int BAND_W    = $clog2(NUM_BANDS);

  // Largest positive value a scaled band may take.
  localparam int S_MAX = 32767;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    MEAN  = 2'd2,
    EMIT  = 2'd3
  } state_e;

  function automatic logic [FEAT_W-1:0] sat_shift(input logic [ACC_W-1:0] v,
                                                  input int unsigned     sh);
    logic [ACC_W-1:0] t;
    t = v >> sh;
    if (t > ACC_W'(S_MAX)) begin
      return FEAT_W'(S_MAX);
    end
    return t[FEAT_W-1:0];
  endfunction

endpackage

// File: rtl/feat_band_acc.sv
// Per-frame band accumulation and frame validation.
// Counts incoming bins, routes each bin into the accumulator of its band,
// checks that fft_last lands exactly on the final bin, and latches the four
// band sums into hold registers when a good frame completes and the output
// engine can take it.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   fft_data           : unsigned bin magnitude, qualified by fft_valid
//   fft_valid          : one bin is presented this cycle (no backpressure)
//   fft_last           : marks the last bin of a frame, only with fft_valid
//   hold_en            : hold registers may be overwritten by a good frame
//   frame_good         : combinational, a good frame completes this cycle
//   frame_err          : registered one-cycle pulse, malformed frame discarded
//   hold               : latched band sums of the last accepted frame
module feat_band_acc
  import audio_feat_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int B1        = 32,
  parameter int B2        = 64,
  parameter int B3        = 128
) (
  input  logic                                sys_clk,
  input  logic                                sys_rst_n,
  input  logic [FEAT_W-1:0]                   fft_data,
  input  logic                                fft_valid,
  input  logic                                fft_last,
  input  logic                                hold_en,
  output logic                                frame_good,
  output logic                                frame_err,
  output logic [NUM_BANDS-1:0][ACC_W-1:0]     hold
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_BIN = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0]                bin_cnt_q, bin_cnt_d;
  logic [NUM_BANDS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [NUM_BANDS-1:0][ACC_W-1:0] hold_q, hold_d;
  logic                            frame_err_q, frame_err_d;

  logic [BAND_W-1:0] band;
  logic              at_last_bin;
  logic [ACC_W-1:0]  sum_cur;

  always_comb begin
    band = BAND_W'(3);
    if (int'(bin_cnt_q) < B1) begin
      band = BAND_W'(0);
    end else if (int'(bin_cnt_q) < B2) begin
      band = BAND_W'(1);
    end else if (int'(bin_cnt_q) < B3) begin
      band = BAND_W'(2);
    end
  end

  assign at_last_bin = (bin_cnt_q == LAST_BIN);
  assign sum_cur     = acc_q[band] + ACC_W'(fft_data);

  always_comb begin
    acc_d       = acc_q;
    hold_d      = hold_q;
    bin_cnt_d   = bin_cnt_q;
    frame_err_d = 1'b0;
    frame_good  = 1'b0;
    if (fft_valid) begin
      if (fft_last) begin
        if (at_last_bin) begin
          frame_good = 1'b1;
          // The closing bin is not yet in acc_q, so fold it in while latching.
          if (hold_en) begin
            hold_d       = acc_q;
            hold_d[band] = sum_cur;
          end
        end else begin
          frame_err_d = 1'b1;
        end
        acc_d     = '0;
        bin_cnt_d = '0;
      end else if (at_last_bin) begin
        // Frame overran without fft_last: discard it and resync to bin 0.
        frame_err_d = 1'b1;
        acc_d       = '0;
        bin_cnt_d   = '0;
      end else begin
        acc_d[band] = sum_cur;
        bin_cnt_d   = bin_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bin_cnt_q   <= '0;
      acc_q       <= '0;
      hold_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bin_cnt_q   <= bin_cnt_d;
      acc_q       <= acc_d;
      hold_q      <= hold_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign hold      = hold_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/band_feature_extract.sv
// Band feature extractor: sums FFT magnitude bins into four bands per frame,
// scales and saturates each band sum, removes the mean of the four scaled
// values, and emits the four mean-removed features as consecutive beats.
//
// Stream protocol: input is valid-only. A bin is transferred on every cycle
// fft_valid is high; there is no ready, so the block accepts every bin.
// Output is likewise valid-only: feature_out carries a feature on every cycle
// feature_out_en is high and holds its value otherwise.
//
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   fft_data           : unsigned bin magnitude
//   fft_valid          : fft_data valid this cycle
//   fft_last           : last bin of a frame, only with fft_valid
//   feature_out        : signed feature, bands 0..3 in order
//   feature_out_en     : feature_out valid, four consecutive beats per frame
//   frame_err          : one-cycle pulse, malformed frame discarded
//   frame_drop         : one-cycle pulse, good frame discarded (engine busy)
//   dbg_state          : current output engine state
module band_feature_extract
  import audio_feat_pkg::*;
#(
  parameter int FRAME_LEN = 256,
  parameter int B1        = 32,
  parameter int B2        = 64,
  parameter int B3        = 128,
  parameter int SHIFT     = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [FEAT_W-1:0] fft_data,
  input  logic              fft_valid,
  input  logic              fft_last,
  output logic [FEAT_W-1:0] feature_out,
  output logic              feature_out_en,
  output logic              frame_err,
  output logic              frame_drop,
  output state_e            dbg_state
);

  // Wide enough for four values of at most S_MAX.
  localparam int SUM_W = FEAT_W + 2;

  logic                             frame_good;
  logic [NUM_BANDS-1:0][ACC_W-1:0]  hold;

  state_e                           state_q;
  logic [NUM_BANDS-1:0][FEAT_W-1:0] s_q, s_d;
  logic [FEAT_W-1:0]                m_q, m_d;
  logic [FEAT_W-1:0]                feature_q, feature_d;
  logic                             feature_en_q;
  logic                             frame_drop_q;
  logic [BAND_W-1:0]                beat_q;

  logic [SUM_W-1:0]  band_sum;
  logic [FEAT_W-1:0] emit_s;
  logic [FEAT_W-1:0] emit_m;

  feat_band_acc #(
    .FRAME_LEN (FRAME_LEN),
    .B1        (B1),
    .B2        (B2),
    .B3        (B3)
  ) u_band_acc (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .fft_data   (fft_data),
    .fft_valid  (fft_valid),
    .fft_last   (fft_last),
    .hold_en    (state_q == IDLE),
    .frame_good (frame_good),
    .frame_err  (frame_err),
    .hold       (hold)
  );

  always_comb begin
    for (int k = 0; k < NUM_BANDS; k++) begin
      s_d[k] = sat_shift(hold[k], SHIFT);
    end

    band_sum = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      band_sum = band_sum + SUM_W'(s_q[k]);
    end
    // Sum is non-negative, so the shift is an exact floor divide by 4.
    m_d = FEAT_W'(band_sum >> 2);

    // Beat 0 is produced on the same edge that registers the mean, so it
    // uses the freshly computed mean; later beats use the registered one.
    if (state_q == MEAN) begin
      emit_s = s_q[0];
      emit_m = m_d;
    end else begin
      emit_s = s_q[beat_q];
      emit_m = m_q;
    end
    // Both operands lie in 0..S_MAX, so the difference always fits FEAT_W.
    feature_d = FEAT_W'($signed({1'b0, emit_s}) - $signed({1'b0, emit_m}));
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      m_q          <= '0;
      feature_q    <= '0;
      feature_en_q <= 1'b0;
      frame_drop_q <= 1'b0;
      beat_q       <= '0;
    end else begin
      frame_drop_q <= frame_good && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (frame_good) begin
            state_q <= SCALE;
          end
        end
        SCALE: begin
          s_q     <= s_d;
          state_q <= MEAN;
        end
        MEAN: begin
          m_q          <= m_d;
          feature_q    <= feature_d;
          feature_en_q <= 1'b1;
          beat_q       <= BAND_W'(1);
          state_q      <= EMIT;
        end
        EMIT: begin
          // beat_q walks 1,2,3 and wraps to 0 once band 3 has been issued.
          if (beat_q != '0) begin
            feature_q <= feature_d;
            beat_q    <= beat_q + BAND_W'(1);
          end else begin
            feature_en_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign feature_out    = feature_q;
  assign feature_out_en = feature_en_q;
  assign frame_drop     = frame_drop_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_band_feature_extract.sv
// Bench for band_feature_extract. Four instances with different parameter
// sets share one clock and reset; only one instance is driven at a time.
// Expected beats come from a frame-level model (band sums, shift, clamp,
// mean) and carry the cycle they must appear in, so latency is checked too.
module tb_band_feature_extract;
  import audio_feat_pkg::*;

  localparam int NI = 4;
  localparam int W  = 50;  // {instance[1:0], cycle[31:0], feature[15:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [15:0] fft_data  [NI];
  logic        fft_valid [NI];
  logic        fft_last  [NI];
  logic [15:0] fout      [NI];
  logic        fen       [NI];
  logic        ferr      [NI];
  logic        fdrop     [NI];
  state_e      dbg       [NI];

  // Parameter sets: default, SHIFT=4, 8-bin frame, 4-bin frame. An 8-bin
  // frame cannot complete inside the 6-cycle busy window of the output
  // engine, so the 4-bin instance is the one that can exercise frame_drop.
  int p_len [NI] = '{256, 256, 8, 4};
  int p_b1  [NI] = '{32, 32, 2, 1};
  int p_b2  [NI] = '{64, 64, 4, 2};
  int p_b3  [NI] = '{128, 128, 6, 3};
  int p_sh  [NI] = '{8, 4, 2, 0};

  band_feature_extract u_def (
    .sys_clk(clk), .sys_rst_n(rst_n), .fft_data(fft_data[0]), .fft_valid(fft_valid[0]),
    .fft_last(fft_last[0]), .feature_out(fout[0]), .feature_out_en(fen[0]),
    .frame_err(ferr[0]), .frame_drop(fdrop[0]), .dbg_state(dbg[0]));

  band_feature_extract #(.SHIFT(4)) u_s4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .fft_data(fft_data[1]), .fft_valid(fft_valid[1]),
    .fft_last(fft_last[1]), .feature_out(fout[1]), .feature_out_en(fen[1]),
    .frame_err(ferr[1]), .frame_drop(fdrop[1]), .dbg_state(dbg[1]));

  band_feature_extract #(.FRAME_LEN(8), .B1(2), .B2(4), .B3(6), .SHIFT(2)) u_f8 (
    .sys_clk(clk), .sys_rst_n(rst_n), .fft_data(fft_data[2]), .fft_valid(fft_valid[2]),
    .fft_last(fft_last[2]), .feature_out(fout[2]), .feature_out_en(fen[2]),
    .frame_err(ferr[2]), .frame_drop(fdrop[2]), .dbg_state(dbg[2]));

  band_feature_extract #(.FRAME_LEN(4), .B1(1), .B2(2), .B3(3), .SHIFT(0)) u_f4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .fft_data(fft_data[3]), .fft_valid(fft_valid[3]),
    .fft_last(fft_last[3]), .feature_out(fout[3]), .feature_out_en(fen[3]),
    .frame_err(ferr[3]), .frame_drop(fdrop[3]), .dbg_state(dbg[3]));

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int err_cnt [NI];
  int drop_cnt[NI];
  int last_err_cyc[NI];
  int err_exp [NI];
  int drop_exp[NI];
  int acc_t   [NI] = '{-100, -100, -100, -100};
  int n_checks = 0;
  int n_errors = 0;

  int frame_buf[4096];
  int t_end;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (fen[i]) obs_q.push_back({2'(i), 32'(cyc), fout[i]});
      if (ferr[i]) begin
        err_cnt[i]++;
        last_err_cyc[i] = cyc;
      end
      if (fdrop[i]) drop_cnt[i]++;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A good frame ending in cycle t is taken only if the engine is idle then;
  // an accepted frame keeps it busy for cycles t+1..t+6.
  function automatic bit accept(input int inst, input int t);
    if (t - acc_t[inst] > 6) begin
      acc_t[inst] = t;
      return 1'b1;
    end
    drop_exp[inst]++;
    return 1'b0;
  endfunction

  function automatic void model_push(input int inst, input int t, input int nbeats);
    longint sums[4];
    longint sc;
    int s[4];
    int m;
    int band;
    for (int k = 0; k < 4; k++) sums[k] = 0;
    for (int j = 0; j < p_len[inst]; j++) begin
      band = (j < p_b1[inst]) ? 0 : (j < p_b2[inst]) ? 1 : (j < p_b3[inst]) ? 2 : 3;
      sums[band] += frame_buf[j];
    end
    for (int k = 0; k < 4; k++) begin
      sc   = sums[k] >> p_sh[inst];
      s[k] = (sc > 32767) ? 32767 : int'(sc);
    end
    m = (s[0] + s[1] + s[2] + s[3]) / 4;
    for (int k = 0; k < nbeats; k++) exp_q.push_back({2'(inst), 32'(t + 3 + k), 16'(s[k] - m)});
  endfunction

  task automatic frame_done(input int inst, input int t);
    if (accept(inst, t)) model_push(inst, t, 4);
  endtask

  task automatic expect_const(input int inst, input int t,
                              input int v0, input int v1, input int v2, input int v3);
    if (accept(inst, t)) begin
      exp_q.push_back({2'(inst), 32'(t + 3), 16'(v0)});
      exp_q.push_back({2'(inst), 32'(t + 4), 16'(v1)});
      exp_q.push_back({2'(inst), 32'(t + 5), 16'(v2)});
      exp_q.push_back({2'(inst), 32'(t + 6), 16'(v3)});
    end
  endtask

  // ---------------- drivers ----------------
  // gap: 0 continuous, 1 idle cycle before every bin but the first, 2 random idles.
  task automatic drive(input int inst, input int n, input bit with_last, input int gap);
    for (int j = 0; j < n; j++) begin
      if ((gap == 1 && j > 0) || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        @(negedge clk);
        fft_valid[inst] = 1'b0;
        fft_last[inst]  = 1'b0;
      end
      @(negedge clk);
      fft_valid[inst] = 1'b1;
      fft_data[inst]  = 16'(frame_buf[j]);
      fft_last[inst]  = with_last && (j == n - 1);
      t_end = cyc;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      fft_valid[i] = 1'b0;
      fft_last[i]  = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    idle_all();
  endtask

  task automatic fill_const(input int n, input int v);
    for (int j = 0; j < n; j++) frame_buf[j] = v;
  endtask

  task automatic fill_rand(input int n);
    for (int j = 0; j < n; j++) frame_buf[j] = int'($urandom_range(0, 65535));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) acc_t[i] = -100;
  endtask

  task automatic drain(input string tag);
    idle();
    repeat (12) @(negedge clk);
    #1;
    chk({tag, "_beats"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_beat"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_err%0d", tag, i), err_cnt[i], err_exp[i]);
      chk($sformatf("%s_drop%0d", tag, i), drop_cnt[i], drop_exp[i]);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t;
    idle_all();
    for (int i = 0; i < NI; i++) fft_data[i] = '0;

    // Reset state, sampled while reset is still held.
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_out%0d", i), fout[i], 0);
      chk($sformatf("rst_en%0d", i), fen[i], 0);
      chk($sformatf("rst_err%0d", i), ferr[i], 0);
      chk($sformatf("rst_drop%0d", i), fdrop[i], 0);
      chk($sformatf("rst_state%0d", i), dbg[i], IDLE);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All bins 256, continuous valid.
    fill_const(256, 256);
    drive(0, 256, 1'b1, 0);
    expect_const(0, t_end, -32, -32, 0, 64);
    drain("flat");

    // Same frame, valid low every other cycle.
    drive(0, 256, 1'b1, 1);
    expect_const(0, t_end, -32, -32, 0, 64);
    drain("flat_gappy");

    // SHIFT=4, upper half at full scale: band 3 saturates.
    for (int j = 0; j < 256; j++) frame_buf[j] = (j >= 128) ? 65535 : 0;
    drive(1, 256, 1'b1, 0);
    expect_const(1, t_end, -8191, -8191, -8191, 24576);
    drain("sat");

    // Early fft_last at bin 100, then a correct all-zero frame.
    fill_rand(101);
    drive(0, 101, 1'b1, 0);
    err_exp[0]++;
    t = t_end;
    idle();
    repeat (3) @(negedge clk);
    #1;
    chk("short_err_cycle", last_err_cyc[0], t + 1);
    fill_const(256, 0);
    drive(0, 256, 1'b1, 0);
    expect_const(0, t_end, 0, 0, 0, 0);
    drain("short");

    // Random frames on three parameter sets.
    for (int r = 0; r < 3; r++) begin
      fill_rand(256);
      drive(0, 256, 1'b1, 2);
      frame_done(0, t_end);
      drain("rand_def");
      fill_rand(256);
      drive(1, 256, 1'b1, 2);
      frame_done(1, t_end);
      drain("rand_s4");
      fill_rand(8);
      drive(2, 8, 1'b1, 2);
      frame_done(2, t_end);
      drain("rand_f8");
    end

    // Overrun without fft_last, then a good frame after the resync.
    fill_rand(8);
    drive(2, 8, 1'b0, 0);
    err_exp[2]++;
    t = t_end;
    fill_rand(8);
    drive(2, 8, 1'b1, 0);
    frame_done(2, t_end);
    idle();
    #1;
    chk("overrun_err_cycle", last_err_cyc[2], t + 1);
    drain("overrun");

    // Back-to-back 8-bin frames: the second ends after the engine is idle.
    fill_rand(8);
    drive(2, 8, 1'b1, 0);
    frame_done(2, t_end);
    fill_rand(8);
    drive(2, 8, 1'b1, 0);
    frame_done(2, t_end);
    drain("b2b_f8");

    // Back-to-back 4-bin frames: the second lands mid-EMIT and is dropped.
    for (int f = 0; f < 3; f++) begin
      fill_rand(4);
      drive(3, 4, 1'b1, 0);
      frame_done(3, t_end);
    end
    drain("b2b_f4");

    // Reset during the second EMIT beat: beats 0 and 1 only, outputs clear at once.
    fill_rand(256);
    drive(0, 256, 1'b1, 0);
    t = t_end;
    void'(accept(0, t));
    model_push(0, t, 2);
    idle();
    for (int k = 0; k < 20 && cyc != t + 4; k++) @(negedge clk);
    chk("emit_wait", cyc, t + 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_emit_out", fout[0], 0);
    chk("rst_emit_en", fen[0], 0);
    chk("rst_emit_state", dbg[0], IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) acc_t[i] = -100;
    drain("rst_emit");
    fill_rand(256);
    drive(0, 256, 1'b1, 0);
    frame_done(0, t_end);
    drain("after_rst_emit");

    // Reset mid-frame: the next frame starts again at bin 0.
    fill_rand(100);
    drive(0, 100, 1'b0, 0);
    do_reset();
    fill_rand(256);
    drive(0, 256, 1'b1, 2);
    frame_done(0, t_end);
    drain("after_rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
